// File: rtl/io_pad_enable_seq.sv
// Power-up sequencer for the IO pad ring: waits for a settled VDDIO power-good,
// enables input buffers, then output drivers, and tears down safely on loss.
module io_pad_enable_seq #(
   parameter int NUM_PADS        = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int SETTLE_CYCLES   = 64,
   parameter int IE_TO_OE_CYCLES = 8,
   parameter int CNT_W           = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwr_good_i,
   input  logic                en_req_i,
   input  logic [NUM_PADS-1:0] oe_core_i,
   output logic [NUM_PADS-1:0] pad_ie_o,
   output logic [NUM_PADS-1:0] pad_oe_o,
   output logic                ready_o,
   output logic                fault_o,
   output logic [2:0]          state_o
);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_WAIT_PG  = 3'd1,
      S_SETTLE   = 3'd2,
      S_IE_ON    = 3'd3,
      S_ACTIVE   = 3'd4,
      S_SHUTDOWN = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IE_OE_LAST  = CNT_W'(IE_TO_OE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic                    w_cnt_clr;
   logic                    w_cnt_inc;
   logic [SYNC_STAGES-1:0]  r_pg_sync;
   logic                    r_pg_d;
   logic                    r_en_d;
   logic [NUM_PADS-1:0]     r_pad_ie;
   logic [NUM_PADS-1:0]     r_pad_oe;
   logic                    r_ready;
   logic                    r_fault;
   logic                    w_pg_s;
   logic                    w_pg_fall;
   logic                    w_en_rise;
   logic                    w_fault_clr;
   logic                    w_fault_set;

   assign w_pg_s    = r_pg_sync[SYNC_STAGES-1];
   assign w_pg_fall = r_pg_d & ~w_pg_s;
   assign w_en_rise = en_req_i & ~r_en_d;

   // A supply drop coinciding with the clear attempt is still a supply loss, so it wins.
   assign w_fault_clr = (r_state == S_OFF) && w_en_rise;
   assign w_fault_set = (!w_pg_s && (r_state == S_IE_ON || r_state == S_ACTIVE)) ||
                        (w_fault_clr && w_pg_fall);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pg_sync <= '0;
         r_pg_d    <= 1'b0;
         r_en_d    <= 1'b0;
      end else begin
         r_pg_sync <= {r_pg_sync[SYNC_STAGES-2:0], pwr_good_i};
         r_pg_d    <= w_pg_s;
         r_en_d    <= en_req_i;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_OFF: begin
            if (en_req_i) w_state_nxt = S_WAIT_PG;
         end
         S_WAIT_PG: begin
            if (!en_req_i) begin
               w_state_nxt = S_OFF;
            end else if (w_pg_s) begin
               w_state_nxt = S_SETTLE;
               w_cnt_clr   = 1'b1;
            end
         end
         S_SETTLE: begin
            if (!w_pg_s) begin
               w_state_nxt = S_WAIT_PG;
               w_cnt_clr   = 1'b1;
            end else if (!en_req_i) begin
               w_state_nxt = S_OFF;
               w_cnt_clr   = 1'b1;
            end else if (r_cnt == SETTLE_LAST) begin
               w_state_nxt = S_IE_ON;
               w_cnt_clr   = 1'b1;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         S_IE_ON: begin
            if (!w_pg_s) begin
               w_state_nxt = S_WAIT_PG;
               w_cnt_clr   = 1'b1;
            end else if (!en_req_i) begin
               w_state_nxt = S_SHUTDOWN;
               w_cnt_clr   = 1'b1;
            end else if (r_cnt == IE_OE_LAST) begin
               w_state_nxt = S_ACTIVE;
               w_cnt_clr   = 1'b1;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!w_pg_s) begin
               w_state_nxt = S_WAIT_PG;
               w_cnt_clr   = 1'b1;
            end else if (!en_req_i) begin
               w_state_nxt = S_SHUTDOWN;
               w_cnt_clr   = 1'b1;
            end
         end
         S_SHUTDOWN: begin
            // en_req_i is deliberately not looked at until the ring is fully off.
            if (!w_pg_s || r_cnt == IE_OE_LAST) begin
               w_state_nxt = S_OFF;
               w_cnt_clr   = 1'b1;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_OFF;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   // Pad enables are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_OFF;
         r_cnt    <= '0;
         r_pad_ie <= '0;
         r_pad_oe <= '0;
         r_ready  <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_pad_ie <= (w_state_nxt == S_IE_ON || w_state_nxt == S_ACTIVE ||
                      w_state_nxt == S_SHUTDOWN) ? '1 : '0;
         r_pad_oe <= (w_state_nxt == S_ACTIVE) ? oe_core_i : '0;
         r_ready  <= (w_state_nxt == S_ACTIVE);
         if (w_fault_set) begin
            r_fault <= 1'b1;
         end else if (w_fault_clr) begin
            r_fault <= 1'b0;
         end
      end
   end

   assign pad_ie_o = r_pad_ie;
   assign pad_oe_o = r_pad_oe;
   assign ready_o  = r_ready;
   assign fault_o  = r_fault;
   assign state_o  = r_state;

endmodule

// File: tb/tb_io_pad_enable_seq.sv
// Directed bench for io_pad_enable_seq: nominal bring-up, settle glitch, supply loss,
// orderly disable, fault clear, async reset, and a per-cycle ordering check.
module tb_io_pad_enable_seq;

   localparam int NP = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pwr_good_i;
   logic          en_req_i;
   logic [NP-1:0] oe_core_i;
   logic [NP-1:0] pad_ie_o;
   logic [NP-1:0] pad_oe_o;
   logic          ready_o;
   logic          fault_o;
   logic [2:0]    state_o;

   int n_assert = 0;
   int n_fail   = 0;

   io_pad_enable_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwr_good_i (pwr_good_i),
      .en_req_i   (en_req_i),
      .oe_core_i  (oe_core_i),
      .pad_ie_o   (pad_ie_o),
      .pad_oe_o   (pad_oe_o),
      .ready_o    (ready_o),
      .fault_o    (fault_o),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic inv_check();
      if (rst_n === 1'b1) begin
         n_assert++;
         assert (pad_oe_o === '0 || (pad_ie_o === '1 && state_o === 3'd4)) else begin
            n_fail++;
            $error("FAIL ordering: oe %0h ie %0h state %0d", pad_oe_o, pad_ie_o, state_o);
         end
      end
   endtask

   // Advance n cycles; afterwards we sit 1 time unit past the last rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         inv_check();
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      pwr_good_i = 1'b0;
      en_req_i   = 1'b0;
      oe_core_i  = '0;
      #3;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_ie",    32'(pad_ie_o), 32'h0);
      chk("rst_oe",    32'(pad_oe_o), 32'h0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);

      // Nominal bring-up; cycle 0 is right after this edge.
      tick(2);
      rst_n = 1'b1; en_req_i = 1'b1; pwr_good_i = 1'b1;
      tick(1);  chk("nom_c1_state", 32'(state_o), 32'd1);
      tick(1);  chk("nom_c2_state", 32'(state_o), 32'd1);
      tick(1);  chk("nom_c3_state", 32'(state_o), 32'd2);
      tick(63); chk("nom_c66_state", 32'(state_o), 32'd2);
      chk("nom_c66_ie", 32'(pad_ie_o), 32'h0);
      tick(1);  chk("nom_c67_state", 32'(state_o), 32'd3);
      chk("nom_c67_ie", 32'(pad_ie_o), 32'hFFFF);
      chk("nom_c67_oe", 32'(pad_oe_o), 32'h0);
      tick(7);  chk("nom_c74_ready", 32'(ready_o), 32'd0);
      tick(1);  chk("nom_c75_state", 32'(state_o), 32'd4);
      chk("nom_c75_ready", 32'(ready_o), 32'd1);
      oe_core_i = 16'h00A5;
      tick(1);  chk("nom_oe_a5", 32'(pad_oe_o), 32'h00A5);
      oe_core_i = 16'h5A00;
      tick(1);  chk("nom_oe_5a00", 32'(pad_oe_o), 32'h5A00);

      // Orderly disable at cycle 77.
      en_req_i = 1'b0;
      tick(1);  chk("dis_state", 32'(state_o), 32'd5);
      chk("dis_oe", 32'(pad_oe_o), 32'h0);
      chk("dis_ie", 32'(pad_ie_o), 32'hFFFF);
      tick(7);  chk("dis_c85_ie", 32'(pad_ie_o), 32'hFFFF);
      tick(1);  chk("dis_c86_state", 32'(state_o), 32'd0);
      chk("dis_c86_ie", 32'(pad_ie_o), 32'h0);

      // Power-good glitch at settle count 30 (SETTLE starts cycle 88).
      oe_core_i = '0;
      en_req_i  = 1'b1;
      tick(1);  chk("gl_c87_state", 32'(state_o), 32'd1);
      tick(31); chk("gl_c118_state", 32'(state_o), 32'd2);
      pwr_good_i = 1'b0;
      tick(3);  chk("gl_c121_state", 32'(state_o), 32'd1);
      chk("gl_c121_fault", 32'(fault_o), 32'd0);
      pwr_good_i = 1'b1;
      tick(2);  chk("gl_c123_state", 32'(state_o), 32'd1);
      tick(1);  chk("gl_c124_state", 32'(state_o), 32'd2);
      tick(63); chk("gl_c187_ie", 32'(pad_ie_o), 32'h0);
      tick(1);  chk("gl_c188_ie", 32'(pad_ie_o), 32'hFFFF);
      chk("gl_c188_fault", 32'(fault_o), 32'd0);
      tick(8);  chk("gl_c196_state", 32'(state_o), 32'd4);

      // Supply loss in ACTIVE with all pads driving.
      oe_core_i = 16'hFFFF;
      tick(1);  chk("loss_oe_on", 32'(pad_oe_o), 32'hFFFF);
      pwr_good_i = 1'b0;
      tick(2);  chk("loss_c199_oe", 32'(pad_oe_o), 32'hFFFF);
      chk("loss_c199_fault", 32'(fault_o), 32'd0);
      tick(1);  chk("loss_oe", 32'(pad_oe_o), 32'h0);
      chk("loss_ie",    32'(pad_ie_o), 32'h0);
      chk("loss_ready", 32'(ready_o), 32'd0);
      chk("loss_fault", 32'(fault_o), 32'd1);
      chk("loss_state", 32'(state_o), 32'd1);

      // Clear attempt coinciding with a pg_s drop: fault must stay set.
      oe_core_i = '0;
      en_req_i  = 1'b0;
      tick(1);  chk("fc_off_state", 32'(state_o), 32'd0);
      chk("fc_off_fault", 32'(fault_o), 32'd1);
      pwr_good_i = 1'b1;
      tick(4);
      pwr_good_i = 1'b0;
      tick(2);
      en_req_i = 1'b1;
      tick(1);  chk("fc_race_state", 32'(state_o), 32'd1);
      chk("fc_race_fault", 32'(fault_o), 32'd1);

      // Clean clear: rising en_req_i in OFF with a steady supply.
      en_req_i = 1'b0;
      tick(1);  chk("fc2_off_state", 32'(state_o), 32'd0);
      pwr_good_i = 1'b1;
      tick(3);
      en_req_i = 1'b1;
      tick(1);  chk("fc2_state", 32'(state_o), 32'd1);
      chk("fc2_fault", 32'(fault_o), 32'd0);

      // Reach ACTIVE again, then assert reset between edges.
      tick(73); chk("ar_active", 32'(state_o), 32'd4);
      oe_core_i = 16'h3C3C;
      tick(1);  chk("ar_oe", 32'(pad_oe_o), 32'h3C3C);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_state", 32'(state_o), 32'd0);
      chk("ar_ie",    32'(pad_ie_o), 32'h0);
      chk("ar_oe0",   32'(pad_oe_o), 32'h0);
      chk("ar_ready", 32'(ready_o), 32'd0);
      chk("ar_fault", 32'(fault_o), 32'd0);
      tick(1);
      rst_n = 1'b1;
      oe_core_i = '0;
      tick(1);  chk("rs_c1_state", 32'(state_o), 32'd1);
      tick(66); chk("rs_c67_state", 32'(state_o), 32'd3);
      chk("rs_c67_ie", 32'(pad_ie_o), 32'hFFFF);
      tick(8);  chk("rs_c75_state", 32'(state_o), 32'd4);

      // SHUTDOWN: re-request is ignored, supply loss goes to OFF without fault.
      en_req_i = 1'b0;
      tick(1);  chk("sd_state", 32'(state_o), 32'd5);
      pwr_good_i = 1'b0;
      en_req_i   = 1'b1;
      tick(2);  chk("sd_c78_state", 32'(state_o), 32'd5);
      chk("sd_c78_ie", 32'(pad_ie_o), 32'hFFFF);
      tick(1);  chk("sd_c79_state", 32'(state_o), 32'd0);
      chk("sd_c79_ie", 32'(pad_ie_o), 32'h0);
      chk("sd_c79_fault", 32'(fault_o), 32'd0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
